// File: rtl/alu_control_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes, R-type
// opcodes (instruction bits [31:21]) and the ALUCtl codes driven to the ALU.
package alu_control_pkg;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [10:0] OPC_ADD = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR = 11'b101_0101_0000;

  typedef enum logic [3:0] {
    ALUCTL_AND     = 4'b0000,
    ALUCTL_ORR     = 4'b0001,
    ALUCTL_ADD     = 4'b0010,
    ALUCTL_SUB     = 4'b0110,
    ALUCTL_PASSB   = 4'b0111,
    ALUCTL_INVALID = 4'b1111
  } aluctl_e;

  // Value presented while the output register is held in reset.
  localparam logic [3:0] ALUCTL_RESET = ALUCTL_ADD;

endpackage

// File: rtl/alu_control_decode.sv
// Purely combinational ALU control decode. ALUOp is resolved first so that
// the opcode bits are only looked at for R-type instructions.
module alu_control_decode
  import alu_control_pkg::*;
(
  input  logic [10:0] opcode,
  input  logic [1:0]  aluop,
  output logic [3:0]  alu_ctl,
  output logic        illegal
);

  always_comb begin
    alu_ctl = ALUCTL_INVALID;
    illegal = 1'b1;
    case (aluop)
      ALUOP_LDST: begin
        alu_ctl = ALUCTL_ADD;
        illegal = 1'b0;
      end
      ALUOP_CBZ: begin
        alu_ctl = ALUCTL_PASSB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        // Exact match only; any unknown or unlisted opcode stays invalid.
        case (opcode)
          OPC_ADD: begin alu_ctl = ALUCTL_ADD; illegal = 1'b0; end
          OPC_SUB: begin alu_ctl = ALUCTL_SUB; illegal = 1'b0; end
          OPC_AND: begin alu_ctl = ALUCTL_AND; illegal = 1'b0; end
          OPC_ORR: begin alu_ctl = ALUCTL_ORR; illegal = 1'b0; end
          default: begin alu_ctl = ALUCTL_INVALID; illegal = 1'b1; end
        endcase
      end
      default: begin
        alu_ctl = ALUCTL_INVALID;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control unit: the combinational decoder wrapped by an optional
// one-cycle output register (REG_OUT=1) with asynchronous reset.
module alu_control
  import alu_control_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic [1:0]  ALUOp,
  output logic [3:0]  ALUCtl,
  output logic        illegal
);

  logic [3:0] dec_ctl;
  logic       dec_illegal;

  alu_control_decode u_decode (
    .opcode  (opcode),
    .aluop   (ALUOp),
    .alu_ctl (dec_ctl),
    .illegal (dec_illegal)
  );

  if (REG_OUT) begin : g_reg
    logic [3:0] ctl_d, ctl_q;
    logic       illegal_d, illegal_q;

    always_comb begin
      ctl_d     = dec_ctl;
      illegal_d = dec_illegal;
    end

    // Reset overrides the registered decode immediately, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q     <= ALUCTL_RESET;
        illegal_q <= 1'b0;
      end else begin
        ctl_q     <= ctl_d;
        illegal_q <= illegal_d;
      end
    end

    assign ALUCtl  = ctl_q;
    assign illegal = illegal_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign ALUCtl  = dec_ctl;
    assign illegal = dec_illegal;
  end

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: registered instance checked one cycle
// after stimulus via an expected-value queue, combinational instance checked at once.
module tb_alu_control;

  logic        clk;
  logic        rst;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic [3:0]  ctl_r, ctl_c;
  logic        ill_r, ill_c;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  alu_control #(.REG_OUT(1'b1)) dut_reg (
    .clk(clk), .rst(rst), .opcode(opcode), .ALUOp(alu_op),
    .ALUCtl(ctl_r), .illegal(ill_r)
  );

  alu_control #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .opcode(opcode), .ALUOp(alu_op),
    .ALUCtl(ctl_c), .illegal(ill_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got ctl=%b ill=%b, want ctl=%b ill=%b",
                  tag, got[4:1], got[0], exp[4:1], exp[0]);
  endtask

  // Reference table: {ALUCtl, illegal}
  function automatic logic [4:0] model(input logic [1:0] op, input logic [10:0] opc);
    if (op === 2'b00) return 5'b0010_0;
    if (op === 2'b01) return 5'b0111_0;
    if (op === 2'b10) begin
      if (opc === 11'b10001011000) return 5'b0010_0;
      if (opc === 11'b11001011000) return 5'b0110_0;
      if (opc === 11'b10001010000) return 5'b0000_0;
      if (opc === 11'b10101010000) return 5'b0001_0;
    end
    return 5'b1111_1;
  endfunction

  // Drive at negedge, check the comb instance immediately, then check the
  // registered instance just after the following rising edge.
  task automatic step(input string tag, input logic [1:0] op, input logic [10:0] opc);
    @(negedge clk);
    alu_op = op;
    opcode = opc;
    exp_q.push_back(model(op, opc));
    #1;
    if (op != 2'b11 && op != 2'b10 || !$isunknown(opc))
      check({tag, "_comb"}, {ctl_c, ill_c}, model(op, opc));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check({tag, "_qempty"}, 5'b0, 5'b1);
    else check({tag, "_reg"}, {ctl_r, ill_r}, exp_q.pop_front());
  endtask

  initial begin
    logic [10:0] legal [4];
    legal[0] = 11'b10001011000;
    legal[1] = 11'b11001011000;
    legal[2] = 11'b10001010000;
    legal[3] = 11'b10101010000;

    rst    = 1'b1;
    alu_op = 2'b10;
    opcode = 11'b11001011000;
    #2;
    check("reset_val", {ctl_r, ill_r}, 5'b0010_0);
    @(posedge clk);
    #1;
    check("reset_hold_edge", {ctl_r, ill_r}, 5'b0010_0);
    @(negedge clk);
    rst = 1'b0;

    step("ldst_x", 2'b00, 11'bx);
    step("cbz_x", 2'b01, 11'bx);
    step("r_add", 2'b10, legal[0]);
    step("r_sub", 2'b10, legal[1]);
    step("r_and", 2'b10, legal[2]);
    step("r_orr", 2'b10, legal[3]);
    step("r_bad", 2'b10, 11'b11111000010);
    step("op11", 2'b11, legal[0]);
    step("r_near", 2'b10, 11'b10001011001);

    // Mid-stream asynchronous reset while SUB is registered.
    step("pre_rst_sub", 2'b10, legal[1]);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {ctl_r, ill_r}, 5'b0010_0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_released_hold", {ctl_r, ill_r}, 5'b0010_0);
    @(posedge clk);
    #1;
    check("first_edge_after_rst", {ctl_r, ill_r}, 5'b0110_0);

    // Comb instance with no clock edge in between.
    @(posedge clk);
    #2;
    alu_op = 2'b10;
    opcode = legal[3];
    #1;
    check("comb_orr_noedge", {ctl_c, ill_c}, 5'b0001_0);
    alu_op = 2'b01;
    #1;
    check("comb_cbz_noedge", {ctl_c, ill_c}, 5'b0111_0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [10:0] opc;
      op  = 2'($urandom_range(0, 3));
      opc = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 3)]
                                        : 11'($urandom);
      step($sformatf("rand%0d", i), op, opc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
